imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the byte-wide instruction memory. Owns the fetch PC.
//  Reads 4 bytes per instruction over a 1-byte, 1-cycle-latency read port and assembles
//  them big-endian (byte at PC -> [31:24]). Buffers words in a DEPTH-entry FIFO and hands
//  them to decode with a valid/ready handshake. Handles branch redirect (flush) and halt.
// PARAMETERS
//  PC_W     64  width of PC / byte address
//  DEPTH    2   instruction FIFO entries (power of 2, >=2)
//  RESET_PC 0   fetch PC after reset (must be 4-byte aligned)
// PORTS
//  clk          in   1     clock, all state on rising edge
//  reset        in   1     synchronous, active-high reset
//  mem_rd       out  1     byte read strobe
//  mem_addr     out  PC_W  byte address for read
//  mem_rdata    in   8     read data, valid the cycle after mem_rd
//  inst_valid   out  1     FIFO head holds a valid instruction
//  inst_ready   in   1     decode accepts head this cycle
//  inst         out  32    head instruction word
//  inst_pc      out  PC_W  byte address of head instruction
//  redirect     in   1     flush and restart fetch at redirect_pc
//  redirect_pc  in   PC_W  new fetch address; bits [1:0] forced to 0
//  halt         in   1     block start of new word fetches
//  fetch_busy   out  1     a word fetch is in flight
// BEHAVIOUR
//  Reset: mem_rd=0, mem_addr=0, inst_valid=0, inst=0, inst_pc=0, fetch_busy=0,
//   fetch_pc=RESET_PC, byte cnt=0, FIFO empty, discard flag clear.
//  FSM: IDLE -> ISSUE (cnt 0..3) -> IDLE, or ISSUE(cnt3) -> ISSUE(cnt0) back-to-back.
//   ISSUE: mem_rd=1, mem_addr=fetch_pc+cnt; cnt increments each cycle.
//   Byte returned cycle after issue k goes to lane [31-8k -: 8] of assembly reg.
//   Cycle after cnt=3 issue: word {b0,b1,b2,b3} pushed with pc=fetch_pc; fetch_pc += 4.
//  Start condition (IDLE->ISSUE, or next word after cnt=3):
//   !halt && !redirect && (fifo_count + inflight_words) < DEPTH.
//   Steady state with ready decode: one word every 4 cycles, mem_rd continuously high.
//  mem_rd/mem_addr are registered outputs; mem_addr holds last value when mem_rd=0.
//  fetch_busy = 1 from first byte issue until cycle the word is pushed.
//  Handshake: inst_valid = (fifo_count != 0); pop when inst_valid && inst_ready.
//   inst/inst_pc stable while inst_valid && !inst_ready.
//   Push and pop same cycle: count unchanged; push into full FIFO impossible by start rule.
//  Redirect (highest priority, any state):
//   FIFO flushed (count=0), fetch_pc <= {redirect_pc[PC_W-1:2],2'b00}, cnt <= 0.
//   mem_rd=0 next cycle; byte returning in that cycle discarded (no write, no push).
//   A pop coinciding with redirect is void: decode must drop that instruction.
//   Issue restarts the cycle after the redirect cycle if start condition holds.
//  Halt: sampled only at word start; an in-flight word always completes and is pushed.
//  PC arithmetic: modulo 2^PC_W; mem_addr = fetch_pc+cnt wraps naturally.
//  Reset mid-fetch: all state to reset values next edge; in-flight byte discarded.
// TESTING
//  Mem byte[i]=i, ready=1 after reset -> inst 0x00010203 @pc0, 0x04050607 @pc4,
//   pushes 4 cycles apart, mem_rd high continuously.
//  ready=0 -> 2 words buffered, mem_rd low after 8 issues; ready=1 -> pc0, pc4, pc8 in order.
//  redirect=1, redirect_pc=0x12 during cnt=2 -> no stale push; next inst 0x10111213 @pc 0x10.
//  FIFO count=1, push and pop same cycle -> count stays 1, inst_valid stays 1.
//  halt=1 at cnt=1 -> current word pushed, then mem_rd=0; halt=0 -> resumes at pc+4.
//  reset=1 at cnt=2 -> next cycle mem_rd=0, inst_valid=0; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: issues four byte reads per word over a 1-cycle-latency
// port, assembles them big-endian, and queues the words for decode behind a small FIFO.
module imem_fetch_ctrl #(
  parameter int unsigned     PC_W     = 64,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_rd,
  output logic [PC_W-1:0] mem_addr,
  input  logic [7:0]      mem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] inst_pc,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            halt,
  output logic            fetch_busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  state_e          state_q;
  logic [1:0]      cnt_q;
  logic [1:0]      ret_lane_q;
  logic            ret_vld_q;
  logic [PC_W-1:0] fetch_pc_q;
  logic [PC_W-1:0] word_pc_q;
  logic [PC_W-1:0] mem_addr_q;
  logic            mem_rd_q;
  logic            busy_q;
  logic [23:0]     asm_q;

  logic [31:0]      fifo_inst_q [DEPTH];
  logic [PC_W-1:0]  fifo_pc_q   [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic [CNT_W:0] occupancy;
  logic           start_ok;
  logic           push;
  logic           pop;
  logic           unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // busy_q counts the word in flight, so the FIFO can never be overrun by a fetch
  always_comb begin
    occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, busy_q};
    start_ok  = !halt && !redirect && (occupancy < (CNT_W+1)'(DEPTH));
    push      = ret_vld_q && (ret_lane_q == 2'd3);
    pop       = (count_q != '0) && inst_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      fetch_pc_q <= RESET_PC;
      word_pc_q  <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      ret_vld_q  <= 1'b0;
      ret_lane_q <= '0;
      asm_q      <= '0;
    end else if (redirect) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      fetch_pc_q <= {redirect_pc[PC_W-1:2], 2'b00};
      mem_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      ret_vld_q  <= 1'b0;
    end else begin
      ret_vld_q  <= (state_q == S_ISSUE);
      ret_lane_q <= cnt_q;
      if (ret_vld_q) begin
        case (ret_lane_q)
          2'd0:    asm_q[23:16] <= mem_rdata;
          2'd1:    asm_q[15:8]  <= mem_rdata;
          2'd2:    asm_q[7:0]   <= mem_rdata;
          default: ;
        endcase
      end
      unique case (state_q)
        S_IDLE: begin
          busy_q <= start_ok;
          if (start_ok) begin
            state_q    <= S_ISSUE;
            cnt_q      <= '0;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= fetch_pc_q;
          end
        end
        S_ISSUE: begin
          busy_q <= 1'b1;
          if (cnt_q != 2'd3) begin
            cnt_q      <= cnt_q + 2'd1;
            mem_addr_q <= fetch_pc_q + PC_W'(cnt_q) + PC_W'(1);
          end else begin
            // fetch_pc advances at the last issue; the pushed word takes its pc from word_pc_q
            word_pc_q  <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + PC_W'(4);
            cnt_q      <= '0;
            if (start_ok) begin
              mem_addr_q <= fetch_pc_q + PC_W'(4);
            end else begin
              state_q  <= S_IDLE;
              mem_rd_q <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_inst_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else if (redirect) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        fifo_inst_q[wr_ptr_q] <= {asm_q, mem_rdata};
        fifo_pc_q[wr_ptr_q]   <= word_pc_q;
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign inst_valid = (count_q != '0);
  assign inst       = fifo_inst_q[rd_ptr_q];
  assign inst_pc    = fifo_pc_q[rd_ptr_q];
  assign fetch_busy = busy_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: byte memory returns the low address byte; expected words are
// queued per scenario and matched against every accepted instruction.
module tb_imem_fetch_ctrl;

  localparam int PC_W = 64;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] word;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            mem_rd;
  logic [PC_W-1:0] mem_addr;
  logic [7:0]      mem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [PC_W-1:0] inst_pc;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            halt;
  logic            fetch_busy;

  exp_t sb[$];
  int   cons_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  imem_fetch_ctrl #(.PC_W(PC_W), .DEPTH(2), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // byte memory: byte[i] = i, one-cycle read latency
  always @(posedge clk) mem_rdata <= mem_rd ? mem_addr[7:0] : 8'hA5;

  function automatic logic [31:0] exp_word(input logic [63:0] pc);
    logic [7:0] b;
    b = pc[7:0];
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  task automatic expect_pc(input logic [63:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = exp_word(pc);
    sb.push_back(e);
  endtask

  // scoreboard: every accepted instruction is compared against the queue head
  always @(negedge clk) begin
    if (!reset && !redirect && inst_valid === 1'b1 && inst_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_inst got pc=%h inst=%h, required none", inst_pc, inst);
      end else begin
        exp_t e;
        e = sb.pop_front();
        cons_q.push_back(cyc);
        if (inst !== e.word || inst_pc !== e.pc)
          begin
            errors++;
            $display("FAIL inst_match got pc=%h inst=%h, required pc=%h inst=%h",
                     inst_pc, inst, e.pc, e.word);
          end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    reset = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = rdy;
    sb.delete();
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic wait_addr(input logic [63:0] a, input string name);
    int n = 0;
    while (!(mem_rd === 1'b1 && mem_addr === a) && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL %s no issue at addr, got mem_rd=%b addr=%h, required addr=%h", name, mem_rd, mem_addr, a);
    end
  endtask

  task automatic drain(input string name, output int lows);
    int n = 0;
    lows = 0;
    while (sb.size() != 0 && n < 80) begin
      step();
      if (mem_rd !== 1'b1) lows++;
      n++;
    end
    inst_ready = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d words outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    repeat (3) step();
    checks += 6;
    if (mem_rd !== 1'b0)     begin errors++; $display("FAIL reset_mem_rd got %b required 0", mem_rd); end
    if (mem_addr !== '0)     begin errors++; $display("FAIL reset_mem_addr got %h required 0", mem_addr); end
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %b required 0", inst_valid); end
    if (inst !== '0)         begin errors++; $display("FAIL reset_inst got %h required 0", inst); end
    if (inst_pc !== '0)      begin errors++; $display("FAIL reset_inst_pc got %h required 0", inst_pc); end
    if (fetch_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", fetch_busy); end
  endtask

  task automatic test_stream();
    int lows;
    do_reset(1'b1);
    cons_q.delete();
    for (int i = 0; i < 4; i++) expect_pc(64'(4 * i));
    wait_addr(64'h0, "stream_first");
    checks++;
    if (fetch_busy !== 1'b1) begin errors++; $display("FAIL stream_busy got %b required 1", fetch_busy); end
    for (int k = 1; k < 4; k++) begin
      step();
      checks++;
      if (mem_rd !== 1'b1 || mem_addr !== 64'(k)) begin
        errors++;
        $display("FAIL stream_addr got rd=%b addr=%h required rd=1 addr=%h", mem_rd, mem_addr, 64'(k));
      end
    end
    drain("stream", lows);
    checks++;
    if (lows != 0) begin errors++; $display("FAIL stream_rd_gap got %0d idle cycles required 0", lows); end
    checks++;
    if (cons_q.size() != 4) begin
      errors++;
      $display("FAIL stream_count got %0d words required 4", cons_q.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (cons_q[i] - cons_q[i-1] != 4) begin
          errors++;
          $display("FAIL stream_spacing got %0d cycles required 4", cons_q[i] - cons_q[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int hi = 0;
    int lows;
    do_reset(1'b0);
    repeat (20) begin
      step();
      if (mem_rd === 1'b1) hi++;
    end
    checks += 4;
    if (hi != 8)             begin errors++; $display("FAIL bp_issues got %0d required 8", hi); end
    if (mem_rd !== 1'b0)     begin errors++; $display("FAIL bp_rd_low got %b required 0", mem_rd); end
    if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b required 1", inst_valid); end
    if (inst !== exp_word(64'h0) || inst_pc !== '0) begin
      errors++;
      $display("FAIL bp_head got pc=%h inst=%h required pc=0 inst=%h", inst_pc, inst, exp_word(64'h0));
    end
    expect_pc(64'h0); expect_pc(64'h4); expect_pc(64'h8);
    inst_ready = 1'b1;
    drain("bp", lows);
  endtask

  task automatic test_redirect();
    int lows;
    do_reset(1'b0);
    wait_addr(64'h6, "redir_wait");
    redirect = 1'b1; redirect_pc = 64'h12;
    step();
    redirect = 1'b0;
    checks += 3;
    if (mem_rd !== 1'b0)     begin errors++; $display("FAIL redir_rd got %b required 0", mem_rd); end
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b required 0", inst_valid); end
    if (fetch_busy !== 1'b0) begin errors++; $display("FAIL redir_busy got %b required 0", fetch_busy); end
    expect_pc(64'h10); expect_pc(64'h14);
    inst_ready = 1'b1;
    wait_addr(64'h10, "redir_restart");
    drain("redir", lows);
  endtask

  task automatic test_push_pop();
    int lows;
    do_reset(1'b0);
    expect_pc(64'h0);
    wait_addr(64'h7, "pp_wait");
    step();
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    checks += 2;
    if (inst_valid !== 1'b1) begin errors++; $display("FAIL pp_valid got %b required 1", inst_valid); end
    if (inst !== exp_word(64'h4) || inst_pc !== 64'h4) begin
      errors++;
      $display("FAIL pp_head got pc=%h inst=%h required pc=4 inst=%h", inst_pc, inst, exp_word(64'h4));
    end
    repeat (3) step();
    checks += 2;
    if (sb.size() != 0) begin errors++; $display("FAIL pp_popped got %0d pending required 0", sb.size()); end
    if (inst_valid !== 1'b1 || inst !== exp_word(64'h4)) begin
      errors++;
      $display("FAIL pp_stable got valid=%b inst=%h required valid=1 inst=%h", inst_valid, inst, exp_word(64'h4));
    end
    expect_pc(64'h4); expect_pc(64'h8);
    inst_ready = 1'b1;
    drain("pp", lows);
  endtask

  task automatic test_halt();
    int hi = 0;
    int lows;
    do_reset(1'b1);
    expect_pc(64'h0);
    wait_addr(64'h1, "halt_wait");
    halt = 1'b1;
    repeat (10) begin
      step();
      if (mem_rd === 1'b1) hi++;
    end
    checks += 3;
    if (hi != 2)             begin errors++; $display("FAIL halt_issues got %0d required 2", hi); end
    if (sb.size() != 0)      begin errors++; $display("FAIL halt_word got %0d pending required 0", sb.size()); end
    if (fetch_busy !== 1'b0) begin errors++; $display("FAIL halt_busy got %b required 0", fetch_busy); end
    halt = 1'b0;
    expect_pc(64'h4);
    wait_addr(64'h4, "halt_resume");
    drain("halt", lows);
  endtask

  task automatic test_reset_mid();
    int lows;
    do_reset(1'b1);
    wait_addr(64'h2, "rst_wait");
    reset = 1'b1;
    step();
    checks += 3;
    if (mem_rd !== 1'b0)     begin errors++; $display("FAIL rstmid_rd got %b required 0", mem_rd); end
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b required 0", inst_valid); end
    if (fetch_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b required 0", fetch_busy); end
    reset = 1'b0;
    expect_pc(64'h0);
    wait_addr(64'h0, "rst_restart");
    drain("rstmid", lows);
  endtask

  task automatic test_wrap();
    int lows;
    do_reset(1'b0);
    halt = 1'b1;
    step();
    redirect = 1'b1; redirect_pc = '1;
    step();
    redirect = 1'b0; halt = 1'b0;
    expect_pc(64'hFFFF_FFFF_FFFF_FFFC); expect_pc(64'h0);
    inst_ready = 1'b1;
    wait_addr(64'hFFFF_FFFF_FFFF_FFFC, "wrap_start");
    drain("wrap", lows);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_push_pop();
    test_halt();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1);
  end

endmodule
